// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register, one-outstanding imem handshake and a one-entry skid buffer.
// Optional perf counters are built only when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall,
  input  logic        ex_take_branch,
  input  logic [31:0] ex_target_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] if_id_IR,
  output logic [31:0] if_id_PC,
  output logic        if_id_valid_inst,
  output logic [31:0] if_fetch_cnt,
  output logic [31:0] if_squash_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, SQUASH} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_data_q, skid_data_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  logic id_accept;
  logic rsp_keep;
  logic req_fire;

  assign id_accept = !id_stall || !valid_q;
  assign rsp_keep  = (state_q == WAIT) && imem_rsp_valid;

  // Re-issue in the same cycle as a kept response gives 1 instr/cycle with 1-cycle memory.
  assign imem_req_valid = rst && !ex_take_branch && !skid_valid_q &&
                          ((state_q == IDLE) || (rsp_keep && id_accept));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign if_id_IR         = ir_q;
  assign if_id_PC         = pc_q;
  assign if_id_valid_inst = valid_q;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_pc_d    = skid_pc_q;
    ir_d         = ir_q;
    pc_d         = pc_q;
    valid_d      = valid_q;

    if (ex_take_branch) begin
      fetch_pc_d   = ex_target_pc;
      valid_d      = 1'b0;
      ir_d         = NOP_INST;
      skid_valid_d = 1'b0;
      // An in-flight request must still drain; SQUASH marks its response for discard.
      if (state_q == WAIT) begin
        state_d = imem_rsp_valid ? IDLE : SQUASH;
      end else if ((state_q == SQUASH) && imem_rsp_valid) begin
        state_d = IDLE;
      end
    end else begin
      if (req_fire) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
        state_d    = WAIT;
      end else if (imem_rsp_valid && (state_q != IDLE)) begin
        state_d = IDLE;
      end

      if (id_accept) begin
        if (skid_valid_q) begin
          ir_d         = skid_data_q;
          pc_d         = skid_pc_q;
          valid_d      = 1'b1;
          skid_valid_d = 1'b0;
        end else if (rsp_keep) begin
          ir_d    = imem_rsp_data;
          pc_d    = req_pc_q;
          valid_d = 1'b1;
        end else begin
          ir_d    = NOP_INST;
          valid_d = 1'b0;
        end
      end else if (rsp_keep) begin
        skid_valid_d = 1'b1;
        skid_data_d  = imem_rsp_data;
        skid_pc_d    = req_pc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= 32'd0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= 32'd0;
      skid_pc_q    <= 32'd0;
      ir_q         <= NOP_INST;
      pc_q         <= 32'd0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_pc_q    <= skid_pc_d;
      ir_q         <= ir_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] squash_cnt_q, squash_cnt_d;
  logic        load_evt;
  logic        squash_evt;

  assign load_evt   = !ex_take_branch && id_accept && (skid_valid_q || rsp_keep);
  assign squash_evt = imem_rsp_valid &&
                      ((state_q == SQUASH) || (ex_take_branch && (state_q == WAIT)));

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + {31'd0, load_evt};
    squash_cnt_d = squash_cnt_q + {31'd0, squash_evt};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q  <= 32'd0;
      squash_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign if_fetch_cnt  = fetch_cnt_q;
  assign if_squash_cnt = squash_cnt_q;
`else
  assign if_fetch_cnt  = 32'd0;
  assign if_squash_cnt = 32'd0;
`endif

  // A response with nothing outstanding means the memory broke the in-order contract.
  a_no_rsp_in_idle: assert property (@(posedge clk) disable iff (!rst)
    !(imem_rsp_valid && (state_q == IDLE)));

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory model with programmable latency/budget and a PC scoreboard.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_stall = 1'b0;
  logic        ex_take_branch = 1'b0;
  logic [31:0] ex_target_pc = 32'd0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic [31:0] if_id_IR;
  logic [31:0] if_id_PC;
  logic        if_id_valid_inst;
  logic [31:0] if_fetch_cnt;
  logic [31:0] if_squash_cnt;

  if_stage #(.RESET_PC(32'h0000_0100), .NOP_INST(NOP)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_stall         (id_stall),
    .ex_take_branch   (ex_take_branch),
    .ex_target_pc     (ex_target_pc),
    .imem_req_valid   (imem_req_valid),
    .imem_req_addr    (imem_req_addr),
    .imem_req_ready   (imem_req_ready),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .if_id_IR         (if_id_IR),
    .if_id_PC         (if_id_PC),
    .if_id_valid_inst (if_id_valid_inst),
    .if_fetch_cnt     (if_fetch_cnt),
    .if_squash_cnt    (if_squash_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  mem_t        mem_q[$];
  logic [31:0] exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  int budget = 0;
  logic        stall_cmd = 1'b0;
  int          br_mode = 0;
  logic [31:0] br_match = 32'd0;
  logic [31:0] br_target = 32'd0;
  logic        br_fired = 1'b0;
  logic        valid_prev = 1'b0;
  logic        stall_prev = 1'b0;
  logic        branch_prev = 1'b0;
  logic        req_prev = 1'b0;
  logic        ready_prev = 1'b0;
  logic [31:0] addr_prev = 32'd0;
  logic        check_b2b = 1'b0;
  int          last_load = -10;

  function automatic logic [31:0] mkdata(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // One clock: check IF/ID, then drive this cycle's inputs and record acceptance.
  task automatic cycle();
    logic        new_load;
    logic [31:0] pc;
    logic [31:0] rsp_addr;
    @(negedge clk);
    cyc++;
    new_load = if_id_valid_inst && !branch_prev && (!stall_prev || !valid_prev);
    if (new_load) begin
      chk("load_queued", 32'(exp_q.size() > 0), 32'd1);
      pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      $display("cycle %0d load pc=%h ir=%h", cyc, if_id_PC, if_id_IR);
      chk("load_pc", if_id_PC, pc);
      chk("load_ir", if_id_IR, mkdata(pc));
      if (check_b2b && last_load >= 0) chk("b2b_gap", 32'(cyc - last_load), 32'd1);
      last_load = cyc;
    end
    id_stall = stall_cmd;
    rsp_addr = 32'd0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rsp_addr = mem_q[0].addr;
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mkdata(rsp_addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data = 32'd0;
    end
    ex_take_branch = 1'b0;
    if ((br_mode == 1 && mem_q.size() > 0 && !imem_rsp_valid && mem_q[0].addr == br_match) ||
        (br_mode == 2 && imem_rsp_valid && rsp_addr == br_match)) begin
      ex_take_branch = 1'b1;
      ex_target_pc = br_target;
      br_mode = 0;
      br_fired = 1'b1;
      $display("cycle %0d redirect to %h", cyc, br_target);
    end
    imem_req_ready = (budget > 0);
    #1;
    if (ex_take_branch) chk("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
    if (req_prev && !ready_prev && !branch_prev && !ex_take_branch && imem_req_valid)
      chk("addr_stable", imem_req_addr, addr_prev);
    if (imem_req_valid && imem_req_ready) begin
      mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
      budget--;
    end
    valid_prev  = if_id_valid_inst;
    stall_prev  = id_stall;
    branch_prev = ex_take_branch;
    req_prev    = imem_req_valid;
    ready_prev  = imem_req_ready;
    addr_prev   = imem_req_addr;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_fire(input string tag);
    for (int i = 0; i < 40 && !br_fired; i++) cycle();
    chk(tag, 32'(br_fired), 32'd1);
  endtask

  task automatic do_reset(input logic full_check);
    @(negedge clk);
    rst = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    ex_take_branch = 1'b0;
    id_stall = 1'b0;
    stall_cmd = 1'b0;
    br_mode = 0;
    br_fired = 1'b0;
    check_b2b = 1'b0;
    last_load = -10;
    mem_q.delete();
    repeat (2) @(negedge clk);
    if (full_check) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_valid_inst", 32'(if_id_valid_inst), 32'd0);
      chk("rst_ir", if_id_IR, NOP);
      chk("rst_pc", if_id_PC, 32'd0);
      chk("rst_fetch_cnt", if_fetch_cnt, 32'd0);
      chk("rst_squash_cnt", if_squash_cnt, 32'd0);
    end
    rst = 1'b1;
    #1;
    $display("reset released req_valid=%b addr=%h", imem_req_valid, imem_req_addr);
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h100);
    valid_prev = 1'b0;
    stall_prev = 1'b0;
    branch_prev = 1'b0;
    req_prev = 1'b0;
    ready_prev = 1'b0;
  endtask

  initial begin
    // Reset state and back-to-back fetch at latency 1.
    do_reset(1'b1);
    lat = 1;
    budget = 3;
    check_b2b = 1'b1;
    push_seq(32'h100, 3);
    run(8);
    chk("b2b_drained", 32'(exp_q.size()), 32'd0);

    // Decode stall while the 0x104 response arrives.
    do_reset(1'b0);
    lat = 1;
    budget = 3;
    push_seq(32'h100, 3);
    run(2);
    stall_cmd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_no_req", 32'(imem_req_valid), 32'd0);
      chk("stall_hold_pc", if_id_PC, 32'h100);
    end
    stall_cmd = 1'b0;
    run(6);
    chk("stall_drained", 32'(exp_q.size()), 32'd0);

    // Redirect while 0x108 is outstanding at latency 3.
    do_reset(1'b0);
    lat = 3;
    budget = 5;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    push_seq(32'h200, 2);
    br_mode = 1;
    br_match = 32'h108;
    br_target = 32'h200;
    wait_fire("redir1_fired");
    cycle();
    chk("redir1_bubble_valid", 32'(if_id_valid_inst), 32'd0);
    chk("redir1_bubble_ir", if_id_IR, NOP);
    for (int i = 0; i < 10 && !imem_req_valid; i++) cycle();
    chk("redir1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("redir1_req_addr", imem_req_addr, 32'h200);
    run(10);
    chk("redir1_drained", 32'(exp_q.size()), 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("redir1_squash_cnt", if_squash_cnt, 32'd1);
`else
    chk("redir1_squash_cnt", if_squash_cnt, 32'd0);
`endif

    // Redirect coincident with a response while decode is stalled.
    do_reset(1'b0);
    lat = 1;
    budget = 3;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h300);
    stall_cmd = 1'b1;
    br_mode = 2;
    br_match = 32'h104;
    br_target = 32'h300;
    wait_fire("redir2_fired");
    cycle();
    chk("redir2_bubble_valid", 32'(if_id_valid_inst), 32'd0);
    chk("redir2_bubble_ir", if_id_IR, NOP);
    chk("redir2_skid_empty_req", 32'(imem_req_valid), 32'd1);
    chk("redir2_req_addr", imem_req_addr, 32'h300);
    run(3);
    stall_cmd = 1'b0;
    run(4);
    chk("redir2_drained", 32'(exp_q.size()), 32'd0);

    // Ten fetches around two redirects with requests in flight.
    do_reset(1'b0);
    lat = 2;
    budget = 12;
    push_seq(32'h400, 3);
    push_seq(32'h500, 7);
    br_mode = 1;
    br_match = 32'h100;
    br_target = 32'h400;
    wait_fire("cnt_redir_a");
    br_fired = 1'b0;
    br_mode = 2;
    br_match = 32'h40C;
    br_target = 32'h500;
    wait_fire("cnt_redir_b");
    run(25);
    chk("cnt_drained", 32'(exp_q.size()), 32'd0);
    $display("counters fetch=%0d squash=%0d", if_fetch_cnt, if_squash_cnt);
`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt", if_fetch_cnt, 32'd10);
    chk("squash_cnt", if_squash_cnt, 32'd2);
`else
    chk("fetch_cnt", if_fetch_cnt, 32'd0);
    chk("squash_cnt", if_squash_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage with the integrated IF/ID pipeline register. It owns the fetch PC and issues one request at a time to the instruction memory over a valid/ready request and response handshake. A one-entry skid buffer absorbs a response that arrives while decode is stalled. It drives `if_id_IR`, `if_id_PC` and `if_id_valid_inst` directly into the decode stage, and it accepts branch/jump redirects from execute.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset.
- `NOP_INST`, 32'h0000_0013, value driven on `if_id_IR` when the register is invalid (`addi x0,x0,0`).

Ports:
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `id_stall` in 1: hold request from the decode hazard unit; the IF/ID register keeps its value.
- `ex_take_branch` in 1: redirect strobe from execute.
- `ex_target_pc` in 32: redirect target, word-aligned.
- `imem_req_valid` out 1: fetch request.
- `imem_req_addr` out 32: request address, equals `fetch_pc`.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_rsp_valid` in 1: response strobe. Responses return in order, at least 1 cycle after acceptance.
- `imem_rsp_data` in 32: instruction word.
- `if_id_IR` out 32: registered instruction.
- `if_id_PC` out 32: registered PC of `if_id_IR`.
- `if_id_valid_inst` out 1: the IF/ID contents are a real instruction.
- `if_fetch_cnt` out 32: instructions loaded into IF/ID (see Configuration).
- `if_squash_cnt` out 32: responses discarded (see Configuration).

## Operation
- FSM states:
  - IDLE: nothing outstanding.
  - WAIT: one request outstanding, keep the response.
  - SQUASH: one request outstanding, discard the response.
- `id_accept = !id_stall || !if_id_valid_inst`.
- Request rule: `imem_req_valid = !ex_take_branch && !skid_valid && (IDLE || (WAIT && imem_rsp_valid && id_accept))`.
- On acceptance (`imem_req_valid && imem_req_ready`):
  - `req_pc <= fetch_pc`.
  - `fetch_pc <= fetch_pc + 4` (mod 2^32, wraps 0xFFFF_FFFC→0).
  - Next state is WAIT.
- Response in WAIT, keep path:
  - if `id_accept` and the skid is empty, load IF/ID with {`imem_rsp_data`, `req_pc`, valid=1};
  - otherwise write the skid with {data, `req_pc`}.
  - The skid is always empty in WAIT, so a response never overflows.
- Response in SQUASH: dropped, next state IDLE, `if_squash_cnt` +1.
- Response with no new acceptance: next state IDLE.
- IF/ID update when `id_accept`, in priority order:
  - skid valid: load from the skid, skid cleared;
  - WAIT response present: load from the response;
  - otherwise: valid<=0 and IR<=`NOP_INST`, PC unchanged.
- IF/ID update when `!id_accept`: all IF/ID fields hold.
- Redirect (`ex_take_branch`=1) has priority over stall and over everything else:
  - `fetch_pc <= ex_target_pc`;
  - IF/ID valid<=0 and IR<=`NOP_INST`;
  - skid cleared;
  - no request is issued that cycle;
  - a WAIT response arriving in the same cycle is dropped and counted as squashed, next state IDLE;
  - WAIT with no response goes to SQUASH;
  - IDLE stays IDLE; SQUASH stays SQUASH.
- Responses in IDLE are protocol errors. They are ignored, and simulation flags them with an assertion.

## Timing
- Reset values (async, while `rst`=0):
  - `fetch_pc`=`RESET_PC`, state IDLE, skid empty;
  - `if_id_valid_inst`=0, `if_id_IR`=`NOP_INST`, `if_id_PC`=0;
  - counters 0.
- `imem_req_valid`=0 while in reset.
- The first request is at `RESET_PC` in the first cycle after `rst` rises.
- Reset mid-operation discards any outstanding response.
- Latency: a response in cycle n appears on `if_id_*` in cycle n+1 when `id_accept`.
- With 1-cycle memory and no stall, throughput is 1 instruction per cycle: the request is re-issued in the cycle its predecessor's response arrives.
- Redirect in cycle n:
  - the request for the target is issued in cycle n+1 (if not in SQUASH);
  - IF/ID shows a bubble in cycle n+1.
- `imem_req_addr` must be stable while `imem_req_valid` is high and `imem_req_ready` is low, unless a redirect arrives.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - `if_fetch_cnt` increments once per cycle in which IF/ID loads a valid instruction;
  - `if_squash_cnt` increments once per discarded response;
  - both wrap at 2^32.
- `IF_PERF_CNT_EN` undefined: both ports are tied to 0 and no counter flops are built.

## Test plan
- Reset → `rst` low, then high with `RESET_PC`=0x100 → `imem_req_addr`=0x100 in the first cycle. Before that, `if_id_valid_inst`=0 and `if_id_IR`=0x00000013.
- Back-to-back fetch, ready=1, latency 1, words A,B,C → `if_id_PC`=0x100,0x104,0x108 on consecutive cycles with IR A,B,C.
- Stall during response: `id_stall`=1 for 3 cycles while the response for 0x104 arrives → IF/ID holds 0x100, the 0x104 word goes to the skid, and no request is issued. After release, IF/ID shows 0x104 and then 0x108, with no loss or duplication.
- Redirect to 0x200 while waiting on 0x108 (latency 3) → the 0x108 response is dropped, `if_squash_cnt`=1, the next `imem_req_addr`=0x200, and the first valid `if_id_PC` after the redirect is 0x200.
- Redirect in the same cycle as a response and with `id_stall`=1 → the response is dropped, IF/ID valid=0 next cycle, and the skid is empty.
- Counters with `IF_PERF_CNT_EN`: 10 fetches and 2 redirects with in-flight requests → `if_fetch_cnt`=10, `if_squash_cnt`=2. Without the macro, both read 0.
